weight_matrix_reader: RTL and testbench

Reads the packed upper-triangular weight store (N·(N+1)/2 entries, entry 0 = w00, then w01…w0(N-1), w11, …, w(N-1)(N-1)) and streams the full symmetric N×N matrix row-major to a downstream consumer over a valid/ready handshake. It sits between the weight buffer and the neuron/MAC update logic and is the read side of the weight store. Lower-triangle entries (i>j) are served from the mirrored stored entry w(j,i).

---
 rtl/weight_matrix_reader.sv | 141 ++++++++++++++
 tb/tb_weight_matrix_reader.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/weight_matrix_reader.sv
// Streams the symmetric N x N weight matrix row-major out of a packed upper-triangular store.
// Optional WMR_SNAPSHOT_EN: freeze the store at start so every beat of a stream sees one copy.
module weight_matrix_reader #(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned N     = 4,
  localparam int unsigned E    = N * (N + 1) / 2,
  localparam int unsigned IW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [E*WIDTH-1:0]   weights_flat,
  input  logic                 start,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_weight,
  output logic [IW-1:0]        out_row,
  output logic [IW-1:0]        out_col,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t             state_q, state_d;
  logic [IW-1:0]      row_q, row_d, col_q, col_d;
  logic [WIDTH-1:0]   weight_q, weight_d;
  logic               valid_q, valid_d;
  logic               last_q, last_d;
  logic               done_q, done_d;
  logic [E*WIDTH-1:0] src;
  logic [IW-1:0]      row_n, col_n;

  // Lower-triangle (i>j) reads are folded onto the stored entry w(j,i).
  function automatic logic [WIDTH-1:0] pick(input logic [E*WIDTH-1:0] store,
                                            input logic [IW-1:0] i,
                                            input logic [IW-1:0] j);
    int unsigned a, b, k;
    a = (i < j) ? 32'(i) : 32'(j);
    b = (i < j) ? 32'(j) : 32'(i);
    k = (a * (2 * N - a + 1)) / 2 + (b - a);
    return store[k*WIDTH +: WIDTH];
  endfunction

`ifdef WMR_SNAPSHOT_EN
  logic [E*WIDTH-1:0] snap_q, snap_d;

  always_comb begin
    snap_d = snap_q;
    if (state_q == IDLE && start) snap_d = weights_flat;
  end

  always_ff @(posedge clk) begin
    if (!rst) snap_q <= '0;
    else      snap_q <= snap_d;
  end

  // The first beat is loaded on the same edge as the snapshot, so it reads the live store.
  assign src = (state_q == IDLE) ? weights_flat : snap_q;
`else
  assign src = weights_flat;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      row_q    <= '0;
      col_q    <= '0;
      weight_q <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      weight_q <= weight_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    weight_d = weight_q;
    valid_d  = valid_q;
    last_d   = last_q;
    done_d   = 1'b0;
    row_n    = row_q;
    col_n    = col_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = STREAM;
          row_d    = '0;
          col_d    = '0;
          weight_d = pick(src, '0, '0);
          valid_d  = 1'b1;
          last_d   = (N == 1);
        end
      end
      STREAM: begin
        if (out_ready) begin
          if (last_q) begin
            state_d  = IDLE;
            row_d    = '0;
            col_d    = '0;
            weight_d = '0;
            valid_d  = 1'b0;
            last_d   = 1'b0;
            done_d   = 1'b1;
          end else begin
            if (col_q == IW'(N - 1)) begin
              col_n = '0;
              row_n = row_q + IW'(1);
            end else begin
              col_n = col_q + IW'(1);
            end
            row_d    = row_n;
            col_d    = col_n;
            weight_d = pick(src, row_n, col_n);
            last_d   = (row_n == IW'(N - 1)) && (col_n == IW'(N - 1));
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_valid  = valid_q;
  assign out_weight = weight_q;
  assign out_row    = row_q;
  assign out_col    = col_q;
  assign out_last   = last_q;
  assign busy       = valid_q;
  assign done       = done_q;

endmodule

// File: tb/tb_weight_matrix_reader.sv
// Directed bench for weight_matrix_reader: full streams, stalls, ignored starts, reset abort, store change.
module tb_weight_matrix_reader;
  localparam int unsigned WIDTH = 5;
  localparam int unsigned N     = 4;
  localparam int unsigned E     = 10;
  localparam int MODE_STALL = 1;
  localparam int MODE_START = 2;
  localparam int MODE_RST   = 4;
  localparam int MODE_MUT   = 8;

  logic               clk = 1'b0;
  logic               rst, start, out_ready;
  logic [E*WIDTH-1:0] weights_flat;
  logic               out_valid, out_last, busy, done;
  logic [WIDTH-1:0]   out_weight;
  logic [1:0]         out_row, out_col;

  int n_checks = 0;
  int n_pass   = 0;
  logic [WIDTH-1:0] st [E];
  int kmap [16] = '{0, 1, 2, 3, 1, 4, 5, 6, 2, 5, 7, 8, 3, 6, 8, 9};

  always #5 clk = ~clk;

  weight_matrix_reader #(.WIDTH(WIDTH), .N(N)) dut (
    .clk(clk), .rst(rst), .weights_flat(weights_flat), .start(start),
    .out_valid(out_valid), .out_ready(out_ready), .out_weight(out_weight),
    .out_row(out_row), .out_col(out_col), .out_last(out_last),
    .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_store();
    for (int k = 0; k < E; k++) weights_flat[k*WIDTH +: WIDTH] = st[k];
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_weight"}, out_weight, 0);
    check({tag, "_row"}, out_row, 0);
    check({tag, "_col"}, out_col, 0);
    check({tag, "_last"}, out_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  task automatic run(input int mode);
    logic [WIDTH-1:0] ex [E];
    int n, cyc, idx, exp_cyc;
    logic stalled;
    logic [31:0] p_w, p_r, p_c, p_l;
    for (int k = 0; k < E; k++) ex[k] = st[k];
    exp_cyc = ((mode & MODE_STALL) != 0) ? 47 : 17;
    start = 1'b1;
    step();
    start = 1'b0;
    check("busy_after_start", busy, 1);
    if ((mode & MODE_MUT) != 0) begin
      st[5] = 5'd31;
      load_store();
`ifndef WMR_SNAPSHOT_EN
      ex[5] = 5'd31;
`endif
    end
    n = 0; cyc = 1; idx = 0; stalled = 1'b0;
    p_w = 0; p_r = 0; p_c = 0; p_l = 0;
    while (n < 16 && cyc < 200) begin
      if (stalled) begin
        check("stall_weight", out_weight, p_w);
        check("stall_row", out_row, p_r);
        check("stall_col", out_col, p_c);
        check("stall_last", out_last, p_l);
      end
      check("valid", out_valid, 1);
      check("done_low", done, 0);
      if ((mode & MODE_RST) != 0 && n == 9) begin
        check("abort_row", out_row, 2);
        check("abort_col", out_col, 1);
        rst = 1'b0;
        step();
        check_idle_zero("rst_mid");
        rst = 1'b1;
        step();
        check("post_rst_valid", out_valid, 0);
        check("post_rst_done", done, 0);
        return;
      end
      out_ready = ((mode & MODE_STALL) != 0) ? (idx % 3 == 0) : 1'b1;
      start = ((mode & MODE_START) != 0) && (n == 3 || n == 15);
      if (out_ready) begin
        check("row", out_row, n / 4);
        check("col", out_col, n % 4);
        check("weight", out_weight, ex[kmap[n]]);
        check("last", out_last, (n == 15));
        n++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        p_w = out_weight; p_r = out_row; p_c = out_col; p_l = out_last;
      end
      step();
      start = 1'b0;
      cyc++;
      idx++;
    end
    check("beat_count", n, 16);
    check("done_high", done, 1);
    check("done_cycle", cyc, exp_cyc);
    check("end_valid", out_valid, 0);
    check("end_busy", busy, 0);
    step();
    check("done_pulse", done, 0);
    check("no_restart", out_valid, 0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; out_ready = 1'b0;
    for (int k = 0; k < E; k++) st[k] = '0;
    load_store();
    step();
    step();
    check_idle_zero("reset");
    rst = 1'b1;
    step();
    check("idle_valid", out_valid, 0);

    for (int k = 0; k < E; k++) st[k] = 5'b11110;
    st[0] = 5'b01000; st[4] = 5'b01000; st[7] = 5'b01000; st[9] = 5'b01000;
    load_store();
    run(0);

    for (int k = 0; k < E; k++) st[k] = WIDTH'(k);
    load_store();
    run(0);
    run(MODE_STALL);
    run(MODE_START);
    run(MODE_RST);
    run(0);
    run(MODE_MUT);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
